// File: rtl/mips_pkg.sv
// Shared widths, index/word types and the hardwired-zero register index for the MIPS datapath.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_rf_read_port.sv
// One combinational register-file read port: zero-index check, optional write bypass, array select.
module mips_rf_read_port #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] regs [1:(2**ADDR_W)-1],
  output logic [DATA_W-1:0] rdata
);

  import mips_pkg::*;

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (raddr == ADDR_W'(REG_ZERO));
  // Bypass terms stay in the expression even with BYPASS=0 so the port shape is identical.
  assign w_hit     = BYPASS && we && (waddr == raddr);

  always_comb begin
    rdata = '0;
    if (!rst && !w_is_zero) begin
      if (w_hit) rdata = wdata;
      else       rdata = regs[raddr];
    end
  end

endmodule

// File: rtl/mips_reg_file.sv
// MIPS general-purpose register file: two combinational read ports, one synchronous write port,
// $0 hardwired to zero, write counter and a never-bypassed debug read port.
module mips_reg_file #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  import mips_pkg::*;

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [1:NREGS-1];
  logic [31:0]       r_wr_count;
  logic              w_wr_en;

  assign w_wr_en = we && (waddr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREGS; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
      r_wr_count    <= r_wr_count + 32'd1;
    end
  end

  assign wr_count = r_wr_count;

  mips_rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd1 (
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr1),
    .regs  (r_regs),
    .rdata (rdata1)
  );

  mips_rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd2 (
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr2),
    .regs  (r_regs),
    .rdata (rdata2)
  );

  always_comb begin
    dbg_data = '0;
    if (!rst && (dbg_addr != ADDR_W'(REG_ZERO))) dbg_data = r_regs[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst && we) begin
      assert (!$isunknown(waddr))
        else $error("mips_reg_file: unknown waddr with we=1");
    end
  end

endmodule
